// File: rtl/mul_ctrl_if.sv
// Issue, multiplier and writeback signals of mul_ctrl, bundled as one interface.
// The slave modport is the controller's view; master is the surrounding EXE stage.
interface mul_ctrl_if #(
    parameter int XLEN = 32
);
    logic              ex_valid_i;
    logic              ex_ready_o;
    logic [2:0]        ex_funct3_i;
    logic [XLEN-1:0]   ex_rs1_i;
    logic [XLEN-1:0]   ex_rs2_i;
    logic [4:0]        ex_rd_i;
    logic              flush_i;
    logic              mul_req_o;
    logic [XLEN-1:0]   mul_a_o;
    logic [XLEN-1:0]   mul_b_o;
    logic              mul_ready_i;
    logic [2*XLEN-1:0] mul_result_i;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [4:0]        wb_rd_o;
    logic [XLEN-1:0]   wb_data_o;
    logic              busy_o;

    modport slave (
        input  ex_valid_i, ex_funct3_i, ex_rs1_i, ex_rs2_i, ex_rd_i, flush_i,
        input  mul_ready_i, mul_result_i, wb_ready_i,
        output ex_ready_o, mul_req_o, mul_a_o, mul_b_o,
        output wb_valid_o, wb_rd_o, wb_data_o, busy_o
    );

    modport master (
        output ex_valid_i, ex_funct3_i, ex_rs1_i, ex_rs2_i, ex_rd_i, flush_i,
        output mul_ready_i, mul_result_i, wb_ready_i,
        input  ex_ready_o, mul_req_o, mul_a_o, mul_b_o,
        input  wb_valid_o, wb_rd_o, wb_data_o, busy_o
    );
endinterface

// File: rtl/mul_ctrl.sv
// RV32M multiply sequencer: strips operand signs, drives the unsigned shift-add
// multiplier through req/ready, re-applies the sign and hands the word to writeback.
module mul_ctrl #(
    parameter int XLEN = 32
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    mul_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FIX  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0]   ONE_X = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE_P = (2*XLEN)'(1);

    state_t            state_reg, state_next;
    logic              accept, take_prod, load_wb;
    logic [1:0]        op_reg;
    logic [4:0]        rd_reg;
    logic              neg_reg;
    logic [XLEN-1:0]   a_reg, b_reg;
    logic [2*XLEN-1:0] prod_reg;
    logic [XLEN-1:0]   wb_data_reg;
    logic [4:0]        wb_rd_reg;

    logic              sa, sb;
    logic [XLEN-1:0]   a_next, b_next;
    logic [2*XLEN-1:0] fix_prod;
    logic [XLEN-1:0]   fix_word;
    logic              unused_funct3;

    // funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
    assign sa     = bus.ex_rs1_i[XLEN-1] & (bus.ex_funct3_i[1:0] != 2'b11);
    assign sb     = bus.ex_rs2_i[XLEN-1] & ~bus.ex_funct3_i[1];
    assign a_next = sa ? (~bus.ex_rs1_i + ONE_X) : bus.ex_rs1_i;
    assign b_next = sb ? (~bus.ex_rs2_i + ONE_X) : bus.ex_rs2_i;

    assign fix_prod = neg_reg ? (~prod_reg + ONE_P) : prod_reg;
    assign fix_word = (op_reg == 2'b00) ? fix_prod[XLEN-1:0] : fix_prod[2*XLEN-1:XLEN];

    assign unused_funct3 = bus.ex_funct3_i[2];

    // Outputs are decoded from the registered state, so reset drops mul_req_o at once.
    assign bus.ex_ready_o = (state_reg == IDLE);
    assign bus.busy_o     = (state_reg != IDLE);
    assign bus.mul_req_o  = (state_reg == REQ);
    assign bus.wb_valid_o = (state_reg == OUT);
    assign bus.mul_a_o    = a_reg;
    assign bus.mul_b_o    = b_reg;
    assign bus.wb_data_o  = wb_data_reg;
    assign bus.wb_rd_o    = wb_rd_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Flush beats every other event in every non-idle state.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        take_prod  = 1'b0;
        load_wb    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.ex_valid_i && !bus.flush_i) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.flush_i) begin
                    state_next = IDLE;
                end else if (bus.mul_ready_i) begin
                    take_prod  = 1'b1;
                    state_next = FIX;
                end
            end
            FIX: begin
                if (bus.flush_i) begin
                    state_next = IDLE;
                end else begin
                    load_wb    = 1'b1;
                    state_next = OUT;
                end
            end
            OUT: begin
                if (bus.flush_i || bus.wb_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_reg      <= 2'b00;
            rd_reg      <= 5'd0;
            neg_reg     <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            prod_reg    <= '0;
            wb_data_reg <= '0;
            wb_rd_reg   <= 5'd0;
        end else begin
            if (accept) begin
                op_reg  <= bus.ex_funct3_i[1:0];
                rd_reg  <= bus.ex_rd_i;
                neg_reg <= sa ^ sb;
                a_reg   <= a_next;
                b_reg   <= b_next;
            end
            if (take_prod) begin
                prod_reg <= bus.mul_result_i;
            end
            if (load_wb) begin
                wb_data_reg <= fix_word;
                wb_rd_reg   <= rd_reg;
            end
        end
    end
endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural multiplier and a result scoreboard
// built from full-width signed/unsigned products.
module tb_mul_ctrl;
    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   hs_count = 0;
    logic [31:0] last_data;
    logic [4:0]  last_rd;

    mul_ctrl_if #(.XLEN(32)) bus ();
    mul_ctrl #(.XLEN(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;
    exp_t q[$];

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Result from full sign/zero-extended operands: no magnitudes involved.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [127:0] ea, eb, pr;
        ea = {{96{a[31] & (op != 2'b11)}}, a};
        eb = {{96{b[31] & ~op[1]}}, b};
        pr = ea * eb;
        return (op == 2'b00) ? pr[31:0] : pr[63:32];
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] x, input bit s);
        return s ? (32'd0 - x) : x;
    endfunction

    // Multiplier stand-in: done pulse after 2 cycles of req for a zero operand, 35 otherwise.
    int m_cnt = 0;
    always @(negedge clk) begin
        if (!bus.mul_req_o) begin
            m_cnt = 0;
            bus.mul_ready_i = 1'b0;
        end else if (bus.mul_ready_i) begin
            bus.mul_ready_i = 1'b0;
        end else begin
            m_cnt++;
            if (m_cnt >= ((bus.mul_a_o == 0 || bus.mul_b_o == 0) ? 2 : 35)) begin
                bus.mul_ready_i  = 1'b1;
                bus.mul_result_i = {32'd0, bus.mul_a_o} * {32'd0, bus.mul_b_o};
            end
        end
    end

    // Per-cycle compare against the scoreboard, then predict the coming edge.
    initial begin
        logic        prev_req, prev_ready, prev_flush, prev_valid, prev_hs, hs;
        logic [31:0] prev_data;
        logic [4:0]  prev_rd;
        exp_t        e;
        prev_req = 0; prev_ready = 0; prev_flush = 0; prev_valid = 0; prev_hs = 0;
        prev_data = 0; prev_rd = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                q.delete();
                prev_req = 0; prev_ready = 0; prev_flush = 0; prev_valid = 0; prev_hs = 0;
                continue;
            end
            chk(bus.ex_ready_o == !bus.busy_o, "ready_vs_busy", 32'(bus.ex_ready_o), 32'(!bus.busy_o));
            if (bus.wb_valid_o) begin
                if (q.size() == 0) begin
                    chk(1'b0, "wb_spurious", bus.wb_data_o, 32'd0);
                end else begin
                    chk(bus.wb_data_o == q[0].data, "wb_data", bus.wb_data_o, q[0].data);
                    chk(bus.wb_rd_o == q[0].rd, "wb_rd", 32'(bus.wb_rd_o), 32'(q[0].rd));
                end
                if (prev_valid && !prev_hs && !prev_flush)
                    chk(bus.wb_data_o == prev_data && bus.wb_rd_o == prev_rd, "wb_stable", bus.wb_data_o, prev_data);
            end
            if (bus.mul_req_o && q.size() > 0) begin
                chk(bus.mul_a_o == q[0].a, "mag_a", bus.mul_a_o, q[0].a);
                chk(bus.mul_b_o == q[0].b, "mag_b", bus.mul_b_o, q[0].b);
            end
            if (prev_req && !prev_ready && !prev_flush)
                chk(bus.mul_req_o == 1'b1, "req_held", 32'(bus.mul_req_o), 32'd1);
            if (prev_ready)
                chk(bus.mul_req_o == 1'b0, "req_gap", 32'(bus.mul_req_o), 32'd0);

            hs = bus.wb_valid_o && bus.wb_ready_i && !bus.flush_i;
            if (hs) begin
                last_data = bus.wb_data_o;
                last_rd   = bus.wb_rd_o;
                hs_count++;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (bus.flush_i && bus.busy_o) q.delete();
            if (bus.ex_valid_i && bus.ex_ready_o && !bus.flush_i) begin
                e.rd   = bus.ex_rd_i;
                e.data = ref_result(bus.ex_funct3_i[1:0], bus.ex_rs1_i, bus.ex_rs2_i);
                e.a    = mag(bus.ex_rs1_i, bus.ex_rs1_i[31] && bus.ex_funct3_i[1:0] != 2'b11);
                e.b    = mag(bus.ex_rs2_i, bus.ex_rs2_i[31] && !bus.ex_funct3_i[1]);
                q.push_back(e);
            end
            prev_req = bus.mul_req_o; prev_ready = bus.mul_ready_i; prev_flush = bus.flush_i;
            prev_valid = bus.wb_valid_o; prev_hs = hs; prev_data = bus.wb_data_o; prev_rd = bus.wb_rd_o;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bit ok = 0;
        bus.ex_valid_i = 1'b1; bus.ex_funct3_i = f; bus.ex_rs1_i = a; bus.ex_rs2_i = b; bus.ex_rd_i = rd;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (bus.ex_ready_o) begin ok = 1; break; end
        end
        chk(ok, "accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.ex_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        bit ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk); #1;
            if (!bus.busy_o) begin ok = 1; break; end
        end
        chk(ok, "idle_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] expv);
        int hs0 = hs_count;
        issue(f, a, b, rd);
        wait_idle(100);
        chk(last_data == expv, name, last_data, expv);
        chk(last_rd == rd, {name, "_rd"}, 32'(last_rd), 32'(rd));
        chk(hs_count == hs0 + 1, {name, "_handshakes"}, 32'(hs_count - hs0), 32'd1);
    endtask

    initial begin
        int hs0, cnt;
        bit ok;
        logic [31:0] d0;
        bus.ex_valid_i = 0; bus.ex_funct3_i = 0; bus.ex_rs1_i = 0; bus.ex_rs2_i = 0; bus.ex_rd_i = 0;
        bus.flush_i = 0; bus.wb_ready_i = 1; bus.mul_ready_i = 0; bus.mul_result_i = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk(bus.mul_req_o == 0 && bus.wb_valid_o == 0 && bus.busy_o == 0, "reset_ctrl",
            {29'd0, bus.mul_req_o, bus.wb_valid_o, bus.busy_o}, 32'd0);
        chk(bus.ex_ready_o == 1, "reset_ex_ready", 32'(bus.ex_ready_o), 32'd1);
        chk(bus.mul_a_o == 0 && bus.mul_b_o == 0 && bus.wb_data_o == 0 && bus.wb_rd_o == 0, "reset_data",
            bus.mul_a_o | bus.mul_b_o | bus.wb_data_o | 32'(bus.wb_rd_o), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul_7x6", OP_MUL, 32'd7, 32'd6, 5'd5, 32'd42);

        issue(OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd9);
        @(negedge clk); #1;
        chk(bus.mul_req_o && bus.mul_a_o == 32'h8000_0000, "mulh_min_a", bus.mul_a_o, 32'h8000_0000);
        chk(bus.mul_b_o == 32'h8000_0000, "mulh_min_b", bus.mul_b_o, 32'h8000_0000);
        wait_idle(100);
        chk(last_data == 32'h4000_0000, "mulh_min", last_data, 32'h4000_0000);

        run_op("mul_min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h0000_0000);
        run_op("mulhsu_ones", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFF);
        run_op("mul_neg3x5", OP_MUL, 32'hFFFF_FFFD, 32'd5, 5'd12, 32'hFFFF_FFF1);

        // Zero operand: fast multiplier path, result within 4 cycles of accept.
        issue(OP_MUL, 32'd0, 32'h1234_5678, 5'd13);
        cnt = 0; ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1; cnt++;
            if (bus.wb_valid_o) begin ok = 1; break; end
        end
        chk(ok && cnt <= 4, "zero_latency", 32'(cnt), 32'd4);
        wait_idle(20);
        chk(last_data == 32'd0, "mul_zero", last_data, 32'd0);

        // Backpressure on MULHU.
        bus.wb_ready_i = 1'b0;
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (bus.wb_valid_o) begin ok = 1; break; end
        end
        chk(ok, "bp_valid_timeout", 32'(ok), 32'd1);
        d0 = bus.wb_data_o;
        chk(d0 == 32'hFFFF_FFFE, "mulhu_ones", d0, 32'hFFFF_FFFE);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk(bus.wb_valid_o && bus.wb_data_o == d0 && bus.wb_rd_o == 5'd14 && !bus.ex_ready_o && bus.busy_o,
                "bp_hold", bus.wb_data_o, d0);
        end
        @(posedge clk); #1;
        bus.wb_ready_i = 1'b1;
        @(posedge clk); #1;
        chk(bus.ex_ready_o == 1 && bus.wb_valid_o == 0, "bp_release", 32'(bus.ex_ready_o), 32'd1);

        // Flush ten cycles into REQ.
        hs0 = hs_count;
        issue(OP_MUL, 32'h0000_1234, 32'h0000_5678, 5'd3);
        repeat (9) @(posedge clk);
        #1 bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        chk(bus.mul_req_o == 0 && bus.busy_o == 0, "flush_req", 32'(bus.mul_req_o), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk(hs_count == hs0, "flush_no_wb", 32'(hs_count - hs0), 32'd0);
        run_op("mul_9x9", OP_MUL, 32'd9, 32'd9, 5'd4, 32'd81);

        // Flush coincident with the done pulse.
        hs0 = hs_count;
        issue(OP_MUL, 32'd3, 32'd4, 5'd7);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (bus.mul_ready_i) begin ok = 1; break; end
        end
        chk(ok, "done_timeout", 32'(ok), 32'd1);
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        chk(bus.busy_o == 0, "flush_done_idle", 32'(bus.busy_o), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk(hs_count == hs0 && !bus.wb_valid_o, "flush_done_drop", 32'(hs_count - hs0), 32'd0);

        // Asynchronous reset mid-REQ.
        issue(OP_MUL, 32'd5, 32'd5, 5'd8);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk(bus.mul_req_o == 0 && bus.busy_o == 0 && bus.ex_ready_o == 1 && bus.wb_valid_o == 0, "rst_mid_ctrl",
            {28'd0, bus.mul_req_o, bus.busy_o, bus.ex_ready_o, bus.wb_valid_o}, 32'd2);
        chk(bus.mul_a_o == 0 && bus.mul_b_o == 0 && bus.wb_data_o == 0 && bus.wb_rd_o == 0, "rst_mid_data",
            bus.mul_a_o | bus.mul_b_o | bus.wb_data_o | 32'(bus.wb_rd_o), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("mul_after_rst", OP_MUL, 32'hFFFF_FFFD, 32'd5, 5'd6, 32'hFFFF_FFF1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

- Sequencing and sign-handling front/back end for the unsigned shift-add multiplier `mul` in the EXE stage.
- Accepts RV32M multiply ops (MUL/MULH/MULHSU/MULHU) from the issue side and converts signed operands to magnitudes.
- Drives `mul` through its req/ready handshake, then re-applies the sign, selects the low or high word and presents the result to writeback with valid/ready flow control.

## Interface

- XLEN, 32, operand width; `mul` is instantiated with the same XLEN.

- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- ex_valid_i  in  1  multiply op offered
- ex_ready_o  out  1  block can accept an op; high only in IDLE
- ex_funct3_i  in  3  [1:0] selects 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; bit 2 ignored
- ex_rs1_i  in  XLEN  multiplicand
- ex_rs2_i  in  XLEN  multiplier
- ex_rd_i  in  5  destination register tag
- flush_i  in  1  kill the in-flight op; wins over accept in the same cycle
- mul_req_o  out  1  request to `mul`; high only in REQ
- mul_a_o  out  XLEN  |rs1| (registered)
- mul_b_o  out  XLEN  |rs2| (registered)
- mul_ready_i  in  1  one-cycle done pulse from `mul`
- mul_result_i  in  2*XLEN  unsigned product from `mul`
- wb_valid_o  out  1  result valid
- wb_ready_i  in  1  writeback consumes the result
- wb_rd_o  out  5  tag of the result
- wb_data_o  out  XLEN  final result
- busy_o  out  1  high in any state other than IDLE

## Operation

- **Accept:** occurs when ex_valid_i & ex_ready_o & ~flush_i. On accept, register:
  - funct3[1:0] and rd
  - sa = rs1[XLEN-1] & (op≠MULHU)
  - sb = rs2[XLEN-1] & (op∈{MUL,MULH})
  - mul_a_o = sa ? −rs1 : rs1
  - mul_b_o = sb ? −rs2 : rs2
  - neg = sa ^ sb
- **Magnitudes:** 0x80000000 negates to 0x80000000, which is correct as an unsigned magnitude. No special case.
- **FSM states:** IDLE, REQ, FIX, OUT.
  - IDLE→REQ on accept.
  - REQ: mul_req_o=1, held continuously. `mul` aborts if req drops, so req must not drop until done or flush.
    - On mul_ready_i: latch mul_result_i into prod, go to FIX. mul_req_o falls the same edge.
    - On flush_i: go to IDLE, discard.
    - If mul_ready_i and flush_i occur together, flush wins.
  - FIX: p = neg ? (~prod + 1) mod 2^(2*XLEN) : prod.
    - wb_data_o = p[XLEN-1:0] for MUL, p[2*XLEN-1:XLEN] otherwise.
    - wb_rd_o = rd, wb_valid_o←1, go to OUT.
    - On flush_i: go to IDLE, no output.
  - OUT: hold wb_valid_o, wb_data_o and wb_rd_o stable until wb_ready_i, then wb_valid_o←0 and go to IDLE.
    - On flush_i: wb_valid_o←0, go to IDLE.
- **Request spacing:** mul_req_o is low for at least one cycle between consecutive requests, because IDLE lasts at least one cycle. This returns `mul` to its IDLE state.
- **No pipelining:** one op in flight. ex_ready_o=0 from the accept edge until the cycle after the OUT handshake or flush.
- **Zero product:** negation of 0 yields 0. No special-casing required.

## Timing

- **Reset (async assert):**
  - State = IDLE.
  - mul_req_o, mul_a_o, mul_b_o, wb_valid_o, wb_data_o, wb_rd_o, busy_o all 0.
  - ex_ready_o = 1.
- **Reset deassert:** synchronous to clk_i.
- **Reset mid-operation:** drops mul_req_o immediately, which aborts `mul`. No output is produced.
- **Latency:** with accept at edge T, mul_req_o is high in cycle T+1.
  - mul_ready_i is seen at edge R; wb_valid_o rises at edge R+1.
  - Total = 1 + (mul latency) + 1 cycles.
  - mul latency is about 2 cycles for a zero operand and about 35 cycles otherwise. The block never depends on it.
- **Back-to-back:** the OUT handshake at edge H allows the next accept at edge H+1.
- **Stability:** mul_a_o and mul_b_o are stable throughout REQ. wb_* outputs are stable throughout OUT.

## Test plan

- MUL 7 × 6 → wb_data_o=42, wb_rd_o matches the issued tag, exactly one wb_valid_o handshake.
- MULH 0x80000000 × 0x80000000 → mul_a_o=mul_b_o=0x80000000, wb_data_o=0x40000000; MUL on the same operands → 0x00000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULHU on the same operands → 0xFFFFFFFE; MUL −3 × 5 → 0xFFFFFFF1.
- MUL 0 × 0x12345678 → 0 and wb_valid_o within 4 cycles of accept. mul_req_o is continuous until mul_ready_i, then low ≥1 cycle before the next op.
- Backpressure: hold wb_ready_i=0 for 5 cycles in OUT → wb_* stable, ex_ready_o=0, busy_o=1. Release → handshake, then ex_ready_o=1 on the next cycle.
- Flush:
  - flush_i 10 cycles into REQ → mul_req_o low the next cycle, no wb_valid_o. The following op 9 × 9 returns 81.
  - flush_i coincident with mul_ready_i → result dropped.
  - rst_ni low mid-REQ → all outputs 0 asynchronously.
